// File: rtl/backsub_pam_detector_if.sv
// Frame-in / decisions-out handshake bundle for the back-substitution PAM detector.
// The detector takes the slave view; the producer/consumer side takes the master view.
interface backsub_pam_detector_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned WL = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WL*N*N-1:0]     Rmatrix_i;
  logic [WL*N-1:0]       Zarray_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [3*N-1:0]        Xhat_o;
  logic                  singular_o;

  modport slave (
    input  in_valid,
    input  Rmatrix_i,
    input  Zarray_i,
    input  out_ready,
    output in_ready,
    output out_valid,
    output Xhat_o,
    output singular_o
  );

  modport master (
    output in_valid,
    output Rmatrix_i,
    output Zarray_i,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  Xhat_o,
    input  singular_o
  );
endinterface

// File: rtl/backsub_pam_detector.sv
// Division-free successive-cancellation 4-PAM detector: one row per cycle, row N-1 down to 0.
// Symbols use 3-bit two's complement in {-3,-1,+1,+3}; an all-zero code means "not yet decided".
module backsub_pam_detector #(
  parameter int unsigned N    = 8,
  parameter int unsigned WL   = 16,
  parameter int unsigned ACCW = WL + 6
) (
  input  logic                   clk,
  input  logic                   rst,
  backsub_pam_detector_if.slave  bus
);
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                 r_state;
  logic [KW-1:0]          r_k;
  logic signed [WL-1:0]   r_rm [N][N];
  logic signed [WL-1:0]   r_z  [N];
  logic [2:0]             r_x  [N];
  logic                   r_sing;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [3*N-1:0]         r_xhat;
  logic                   r_sing_o;

  logic signed [ACCW-1:0] w_acc, w_term, w_rkk, w_tn, w_rn, w_thr, w_nthr;
  logic [2:0]             w_xk;
  logic [3*N-1:0]         w_xpack;

  // Interference cancellation and slicing for the current row r_k.
  always_comb begin
    w_acc  = ACCW'(r_z[r_k]);
    w_term = '0;
    for (int j = 0; j < N; j++) begin
      w_term = ACCW'(r_rm[r_k][j]);
      if (j > int'(r_k)) begin
        case (r_x[j])
          3'b001:  w_acc = w_acc - w_term;
          3'b011:  w_acc = w_acc - (w_term + (w_term <<< 1));
          3'b111:  w_acc = w_acc + w_term;
          3'b101:  w_acc = w_acc + (w_term + (w_term <<< 1));
          default: w_acc = w_acc;
        endcase
      end
    end
    w_rkk = ACCW'(r_rm[r_k][r_k]);
    // Fold a negative diagonal into the residual so the slicer only sees r' >= 0.
    if (w_rkk[ACCW-1]) begin
      w_tn = -w_acc;
      w_rn = -w_rkk;
    end else begin
      w_tn = w_acc;
      w_rn = w_rkk;
    end
    w_thr  = w_rn <<< 1;
    w_nthr = -w_thr;
    if (w_tn >= w_thr)       w_xk = 3'b011;
    else if (!w_tn[ACCW-1])  w_xk = 3'b001;
    else if (w_tn >= w_nthr) w_xk = 3'b111;
    else                     w_xk = 3'b101;
    w_xpack = '0;
    for (int k = 0; k < N; k++) begin
      w_xpack[3*k +: 3] = (k == int'(r_k)) ? w_xk : r_x[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_k         <= '0;
      r_sing      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_xhat      <= '0;
      r_sing_o    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_z[i] <= '0;
        r_x[i] <= '0;
        for (int j = 0; j < N; j++) r_rm[i][j] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            for (int i = 0; i < N; i++) begin
              r_z[i] <= bus.Zarray_i[i*WL +: WL];
              r_x[i] <= '0;
              for (int j = 0; j < N; j++) r_rm[i][j] <= bus.Rmatrix_i[(i*N+j)*WL +: WL];
            end
            r_k        <= KW'(N - 1);
            r_sing     <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= StCalc;
          end
        end
        StCalc: begin
          r_x[r_k] <= w_xk;
          if (w_rkk == '0) r_sing <= 1'b1;
          if (r_k == '0) begin
            r_xhat      <= w_xpack;
            r_sing_o    <= r_sing | (w_rkk == '0);
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_k <= r_k - KW'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.Xhat_o     = r_xhat;
  assign bus.singular_o = r_sing_o;
endmodule

// File: doc/backsub_pam_detector.md
Name: backsub_pam_detector

Overview:
- Division-free successive-cancellation (back-substitution) detector for the real-valued MIMO model.
- Consumes the upper-triangular R and rotated observation z = Q^T y produced by the final Givens rotation stage of the QR chain.
- Detects one 4-PAM symbol per cycle, from row N-1 down to row 0, then presents the packed decision vector to the output stage.
- Uses valid/ready handshakes on both sides.

Parameters:
- N, 8, real-valued matrix dimension (4x4 complex represented as 8x8 real).
- WL, `WL, signed word length of each R and z element, taken from parameters.v.
- ACCW, `WL+6, signed width of the interference accumulator and slicer datapath.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  R/z frame present.
- in_ready  out  1  block can accept a frame.
- Rmatrix_i  in  WL*N*N  row i at [(i+1)*WL*N-1 : i*WL*N]; element j of a row at [(j+1)*WL-1 : j*WL]; signed; entries below the diagonal are ignored.
- Zarray_i  in  WL*N  element i at [(i+1)*WL-1 : i*WL]; signed.
- out_valid  out  1  decisions valid.
- out_ready  in  1  downstream accepts decisions.
- Xhat_o  out  3*N  symbol k at [3k+2 : 3k], 3-bit two's complement in {-3,-1,+1,+3}.
- singular_o  out  1  at least one r_kk == 0 in this frame; valid with out_valid.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State = IDLE, in_ready=1, out_valid=0, Xhat_o=0, singular_o=0.
  - Row index and internal R/z registers are cleared.
  - Reset mid-CALC or mid-DONE aborts the frame with no output.
- Clocking and reset:
  - Single clock domain; all state registered on posedge clk.
  - Synchronous reset only; no negedge or async terms.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at edge E0: latch Rmatrix_i and Zarray_i, set k=N-1, clear the symbol register and singular flag, go to CALC.
- CALC:
  - in_ready=0. One row per cycle, at edges E1..EN (row k at edge E(N-k)).
  - Interference: t = z_k - sum over j=k+1..N-1 of r_kj*x_j, using already-decided x_j.
  - Products use shift/add only: x in {±1,±3}, so the product is ±r or ±(r + 2r).
  - Rows with no decided symbols (k=N-1) give t = z_k.
  - Sign normalisation: if r_kk < 0, t' = -t and r' = -r_kk; otherwise t' = t and r' = r_kk.
  - Slicer (division-free), with T = 2*r' in ACCW bits:
    - x_k = +3 if t' >= T.
    - x_k = +1 if 0 <= t' < T.
    - x_k = -1 if -T <= t' < 0.
    - x_k = -3 if t' < -T.
  - Ties: t'=0 gives +1; t'=T gives +3; t'=-T gives -1.
  - r_kk == 0: T=0, so x_k = +3 if t >= 0, else -3; set singular_o sticky for the frame.
  - After row 0 (edge EN): go to DONE.
- DONE:
  - out_valid=1; Xhat_o and singular_o are held stable.
  - When out_valid && out_ready at an edge: go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
  - No same-cycle accept of a new frame. Minimum frame period is N+2 cycles.
- Latency: out_valid rises in the cycle after edge EN, i.e. N+1 edges after acceptance.
- Arithmetic:
  - All sums are in ACCW bits, with operands sign-extended from WL.
  - No saturation is needed: N-1 terms of magnitude 3*2^(WL-1), plus z, fit in WL+6 bits.
- in_valid while not in IDLE is ignored; the upstream holds the frame until in_ready.
- Xhat_o outside DONE holds the last frame's value; it is only meaningful while out_valid=1.

Test Plan:
- Diagonal decode: R=64*I, z=[192,64,-64,-192,192,64,-64,-192] (index 0 first) → Xhat = [+3,+1,-1,-3,+3,+1,-1,-3]; out_valid first high 9 edges after acceptance; singular_o=0.
- Cancellation: R=64*I plus r_67=32, z_7=192, z_6=32, other z=64 → x7=+3; t6=32-96=-64 gives x6=-1; rest +1.
- Negative diagonal and ties: r_77=-64, z_7=-128 → x7=+3 (t'=128=T); r_66=64, z_6=0 → x6=+1; r_55=64, z_5=-128 → x5=-1.
- Singular: r_33=0 with z_3=-5 → x3=-3 and singular_o=1; the next frame with full rank shows singular_o=0.
- Backpressure: hold out_ready=0 for 20 cycles → out_valid and Xhat_o stay stable and in_ready=0; release → exactly one transfer, in_ready=1 on the following cycle.
- Reset mid-CALC: assert rst at edge E3 → out_valid=0, in_ready=1 next cycle; a new frame then decodes correctly with no stale symbols.
